eth_frame_bist: RTL and testbench
=================================

# eth_frame_bist

Synthesizable Ethernet frame built-in self-test block: a parametrised AXI-Stream frame generator plus an independent checker for loopback testing. It drives the TX stream toward the MAC/iDMA path and checks frames returning on the RX stream. Per-frame length, frame count and payload pattern are run-time configurable. Frame, error and first-mismatch status are exposed for a register file.

## Interface
Parameters:
- DataWidth, 64: stream width in bits; multiple of 32, ≥32; B = DataWidth/8 bytes per beat.
- LenWidth, 16: width of the frame-length field (bytes).
- CntWidth, 32: width of frame and error counters.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  single-cycle run request.
- cfg_len_i  in  LenWidth  bytes per frame; sampled on accepted start.
- cfg_num_frames_i  in  CntWidth  frames per run; sampled on accepted start.
- cfg_mode_i  in  2  pattern: 0 INCR, 1 PRBS, 2 CONST, 3 reserved (treated as CONST).
- cfg_seed_i  in  32  PRBS seed (0 replaced by 32'h1); CONST byte = seed[7:0].
- tx_tdata_o  out  DataWidth  generated data.
- tx_tkeep_o  out  B  byte enables.
- tx_tlast_o  out  1  last beat of a frame.
- tx_tvalid_o  out  1  TX valid.
- tx_tready_i  in  1  TX ready.
- rx_tdata_i  in  DataWidth  returned data.
- rx_tkeep_i  in  B  byte enables.
- rx_tlast_i  in  1  last beat.
- rx_tvalid_i  in  1  RX valid.
- rx_tready_o  out  1  always 1 out of reset (sink never stalls).
- busy_o  out  1  run in progress.
- done_o  out  1  run complete; level.
- tx_frames_o  out  CntWidth  frames fully sent.
- rx_frames_o  out  CntWidth  frames received (tlast seen).
- err_beats_o  out  CntWidth  mismatching or unexpected RX beats.
- len_err_o  out  CntWidth  frames whose tlast came on the wrong beat.
- first_err_valid_o  out  1  first-error capture holds data.
- first_err_frame_o  out  CntWidth  frame index of first error.
- first_err_beat_o  out  LenWidth  beat index of first error.

## Operation
- Start is accepted only when busy_o=0, cfg_len_i≠0 and cfg_num_frames_i≠0; otherwise ignored.
- Accepted start clears all counters, done_o and the first-error capture, latches the config, seeds both LFSRs and sets busy_o.
- Beats per frame: NB = ceil(len/B).
  - Last-beat tkeep: low (len mod B) bits set, or all ones if the remainder is 0.
  - All other beats: all ones.
- Patterns, for byte offset k within frame f and beat n:
  - INCR: byte = (f + k) mod 256.
  - PRBS: 32-bit Galois LFSR, x^32+x^22+x^2+x+1, advanced once per accepted beat (continuous across frames); word = LFSR replicated DataWidth/32 times.
  - CONST: every byte = seed[7:0].
- Generator FSM: IDLE → SEND (accepted start) → IDLE after the last beat of frame num_frames-1 is accepted.
  - Frame and beat counters advance only on a tx handshake.
  - tx_tlast_o is set on beat NB-1.
- Checker FSM: IDLE → CHECK (accepted start) → IDLE when rx_frames reaches num_frames; independent of the generator.
  - It runs its own pattern source, advanced per rx handshake.
  - Each handshaked beat compares only bytes enabled by the expected tkeep; a tkeep mismatch also counts as a data mismatch.
- Length checks:
  - tlast on a beat < NB-1: len_err_o increments, and the frame closes.
  - No tlast on beat NB-1: len_err_o increments, and the checker resynchronises on the next tlast.
  - PRBS continues advancing per beat in both cases.
- err_beats_o increments at most once per beat. RX beats accepted while the checker is IDLE also count into err_beats_o.
- First error (data or length) latches frame and beat indices; further errors do not overwrite it.
- busy_o falls when both FSMs are IDLE; done_o rises on the same edge.
- Counters saturate at all-ones.

## Timing
- Reset values:
  - tx_tvalid_o=0, tx_tlast_o=0, tx_tdata_o=0, tx_tkeep_o=0.
  - rx_tready_o=1.
  - busy_o=0, done_o=0.
  - All counters 0, first_err_valid_o=0, first_err_frame_o=0, first_err_beat_o=0.
- tx_tvalid_o is asserted the cycle after an accepted start; beats stream back-to-back at full rate while tx_tready_i=1.
- tdata, tkeep and tlast hold stable while tvalid=1 and tready=0; tvalid never drops without a handshake.
- Counter and status updates are visible one cycle after the handshake that causes them.
- done_o is high from the cycle after the final RX tlast until the next accepted start, which clears it in the same cycle busy_o rises.
- A start coinciding with the final RX beat is ignored (busy_o still 1).
- rst_i asserted mid-run returns everything to reset values on the next edge; no partial frame is completed.

## Structure
- Package eth_bist_pkg: mode enum (INCR/PRBS/CONST), generator/checker state enum, LFSR polynomial constant and next-state function, tkeep-from-remainder function.
- Sub-module eth_bist_pattern_gen holds the per-beat pattern state (frame index, byte offset, LFSR). It is instantiated once for the generator and once for the checker.

## Test plan
- DataWidth=64, len=64, 4 frames, INCR, tready=1, loopback tx→rx: 32 TX beats, tx_frames=rx_frames=4, err_beats=0, done_o=1, tkeep always 8'hFF.
- len=61, 2 frames, PRBS seed 32'hACE1: 8 beats/frame, last tkeep=8'h1F, no errors; seed 0 behaves as seed 1.
- Random tready (50%) in INCR: data and tkeep stable while stalled, and results identical to the full-rate case.
- Flip one bit of frame 2, beat 3 in the loopback: err_beats=1, first_err frame=2, beat=3; a later injected error leaves the capture unchanged.
- Early tlast on beat 5 of an 8-beat frame: len_err=1 and the following frames check cleanly; an RX beat after done counts err_beats+1.
- start with len=0 → ignored; rst_i mid-frame → all outputs at reset values next cycle, and a new start runs clean.

Source files
------------

// File: rtl/eth_bist_pkg.sv
// rtl/eth_bist_pkg.sv - shared types and helpers for the Ethernet frame BIST
package eth_bist_pkg;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_PRBS  = 2'd1,
        MODE_CONST = 2'd2
    } mode_e;

    typedef enum logic {
        GEN_IDLE = 1'b0,
        GEN_SEND = 1'b1
    } gen_state_e;

    typedef enum logic {
        CHK_IDLE  = 1'b0,
        CHK_CHECK = 1'b1
    } chk_state_e;

    // Right-shifting Galois toggle mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // Last-beat byte enable for byte idx; a zero remainder means a full beat
    function automatic logic keep_bit(input logic [7:0] rem, input logic [7:0] idx);
        return (rem == 8'd0) || (idx < rem);
    endfunction

endpackage

// File: rtl/eth_bist_pattern_gen.sv
// rtl/eth_bist_pattern_gen.sv - per-beat pattern source (frame index, byte offset, LFSR)
module eth_bist_pattern_gen
    import eth_bist_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 init_i,
    input  logic [1:0]           mode_i,
    input  logic [31:0]          seed_i,
    input  logic                 step_i,
    input  logic                 last_i,
    output logic [DataWidth-1:0] data_o
);
    localparam int B = DataWidth / 8;

    mode_e       mode_q, mode_d;
    logic [7:0]  frame_q, frame_d;
    logic [7:0]  off_q, off_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [7:0]  cbyte_q, cbyte_d;

    always_comb begin
        mode_d  = mode_q;
        frame_d = frame_q;
        off_d   = off_q;
        lfsr_d  = lfsr_q;
        cbyte_d = cbyte_q;
        if (init_i) begin
            mode_d  = (mode_i == 2'd3) ? MODE_CONST : mode_e'(mode_i);
            frame_d = '0;
            off_d   = '0;
            lfsr_d  = (seed_i == 32'h0) ? 32'h1 : seed_i;
            cbyte_d = seed_i[7:0];
        end else if (step_i) begin
            lfsr_d = lfsr_next(lfsr_q);
            if (last_i) begin
                frame_d = frame_q + 8'd1;
                off_d   = '0;
            end else begin
                off_d = off_q + 8'(B);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_INCR;
            frame_q <= '0;
            off_q   <= '0;
            lfsr_q  <= 32'h1;
            cbyte_q <= '0;
        end else begin
            mode_q  <= mode_d;
            frame_q <= frame_d;
            off_q   <= off_d;
            lfsr_q  <= lfsr_d;
            cbyte_q <= cbyte_d;
        end
    end

    always_comb begin
        data_o = '0;
        case (mode_q)
            MODE_INCR: begin
                for (int i = 0; i < B; i++) data_o[8*i +: 8] = frame_q + off_q + 8'(i);
            end
            MODE_PRBS: data_o = {(DataWidth/32){lfsr_q}};
            default:   data_o = {B{cbyte_q}};
        endcase
    end

endmodule

// File: rtl/eth_frame_bist.sv
// rtl/eth_frame_bist.sv - AXI-Stream frame generator and independent loopback checker
module eth_frame_bist
    import eth_bist_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int LenWidth  = 16,
    parameter int CntWidth  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [LenWidth-1:0]    cfg_len_i,
    input  logic [CntWidth-1:0]    cfg_num_frames_i,
    input  logic [1:0]             cfg_mode_i,
    input  logic [31:0]            cfg_seed_i,
    output logic [DataWidth-1:0]   tx_tdata_o,
    output logic [DataWidth/8-1:0] tx_tkeep_o,
    output logic                   tx_tlast_o,
    output logic                   tx_tvalid_o,
    input  logic                   tx_tready_i,
    input  logic [DataWidth-1:0]   rx_tdata_i,
    input  logic [DataWidth/8-1:0] rx_tkeep_i,
    input  logic                   rx_tlast_i,
    input  logic                   rx_tvalid_i,
    output logic                   rx_tready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CntWidth-1:0]    tx_frames_o,
    output logic [CntWidth-1:0]    rx_frames_o,
    output logic [CntWidth-1:0]    err_beats_o,
    output logic [CntWidth-1:0]    len_err_o,
    output logic                   first_err_valid_o,
    output logic [CntWidth-1:0]    first_err_frame_o,
    output logic [LenWidth-1:0]    first_err_beat_o
);
    localparam int B = DataWidth / 8;
    localparam logic [LenWidth-1:0] B_LEN = LenWidth'(B);

    gen_state_e          gen_q, gen_d;
    chk_state_e          chk_q, chk_d;
    logic [LenWidth-1:0] last_beat_q, last_beat_d;
    logic [B-1:0]        keep_last_q, keep_last_d;
    logic [CntWidth-1:0] num_q, num_d;
    logic [LenWidth-1:0] tx_beat_q, tx_beat_d, rx_beat_q, rx_beat_d;
    logic [CntWidth-1:0] tx_frames_q, tx_frames_d, rx_frames_q, rx_frames_d;
    logic [CntWidth-1:0] err_beats_q, err_beats_d, len_err_q, len_err_d;
    logic [CntWidth-1:0] first_frame_q, first_frame_d;
    logic [LenWidth-1:0] first_beat_q, first_beat_d;
    logic                first_valid_q, first_valid_d, done_q, done_d, resync_q, resync_d;

    logic                 busy, start_acc, tx_hs, tx_last_beat, chk_run, rx_at_last;
    logic                 data_err, early, missing;
    logic [7:0]           rem8;
    logic [B-1:0]         exp_keep;
    logic [DataWidth-1:0] gen_data, chk_data, exp_mask;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign busy         = (gen_q != GEN_IDLE) || (chk_q != CHK_IDLE);
    assign start_acc    = start_i && !busy && (|cfg_len_i) && (|cfg_num_frames_i);
    assign rem8         = 8'(cfg_len_i % B_LEN);

    assign tx_tvalid_o  = (gen_q == GEN_SEND);
    assign tx_last_beat = (tx_beat_q == last_beat_q);
    assign tx_tlast_o   = tx_tvalid_o && tx_last_beat;
    assign tx_tkeep_o   = !tx_tvalid_o ? '0 : (tx_last_beat ? keep_last_q : '1);
    assign tx_tdata_o   = tx_tvalid_o ? gen_data : '0;
    assign tx_hs        = tx_tvalid_o && tx_tready_i;

    assign rx_tready_o  = 1'b1;
    assign chk_run      = (chk_q == CHK_CHECK);
    assign rx_at_last   = (rx_beat_q == last_beat_q);
    assign exp_keep     = rx_at_last ? keep_last_q : '1;

    always_comb begin
        exp_mask = '0;
        for (int i = 0; i < B; i++) exp_mask[8*i +: 8] = {8{exp_keep[i]}};
    end

    // While resynchronising after a missing tlast, beats are not compared
    assign data_err = chk_run && !resync_q &&
                      ((rx_tkeep_i != exp_keep) || (|((rx_tdata_i ^ chk_data) & exp_mask)));
    assign early    = chk_run && !resync_q && rx_tlast_i && (rx_beat_q < last_beat_q);
    assign missing  = chk_run && !resync_q && !rx_tlast_i && rx_at_last;

    eth_bist_pattern_gen #(.DataWidth(DataWidth)) u_gen_pat (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .init_i (start_acc),
        .mode_i (cfg_mode_i),
        .seed_i (cfg_seed_i),
        .step_i (tx_hs),
        .last_i (tx_last_beat),
        .data_o (gen_data)
    );

    eth_bist_pattern_gen #(.DataWidth(DataWidth)) u_chk_pat (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .init_i (start_acc),
        .mode_i (cfg_mode_i),
        .seed_i (cfg_seed_i),
        .step_i (rx_tvalid_i && chk_run),
        .last_i (rx_tlast_i),
        .data_o (chk_data)
    );

    always_comb begin
        gen_d = gen_q;  chk_d = chk_q;
        last_beat_d = last_beat_q;  keep_last_d = keep_last_q;  num_d = num_q;
        tx_beat_d = tx_beat_q;  rx_beat_d = rx_beat_q;
        tx_frames_d = tx_frames_q;  rx_frames_d = rx_frames_q;
        err_beats_d = err_beats_q;  len_err_d = len_err_q;
        first_valid_d = first_valid_q;  first_frame_d = first_frame_q;  first_beat_d = first_beat_q;
        done_d = done_q;  resync_d = resync_q;
        if (start_acc) begin
            gen_d = GEN_SEND;  chk_d = CHK_CHECK;
            last_beat_d = (cfg_len_i - 1'b1) / B_LEN;
            for (int i = 0; i < B; i++) keep_last_d[i] = keep_bit(rem8, 8'(i));
            num_d = cfg_num_frames_i;
            tx_beat_d = '0;  rx_beat_d = '0;
            tx_frames_d = '0;  rx_frames_d = '0;  err_beats_d = '0;  len_err_d = '0;
            first_valid_d = 1'b0;  first_frame_d = '0;  first_beat_d = '0;
            done_d = 1'b0;  resync_d = 1'b0;
        end else begin
            if (tx_hs) begin
                if (tx_last_beat) begin
                    tx_beat_d   = '0;
                    tx_frames_d = sat_inc(tx_frames_q);
                    if (tx_frames_q == num_q - 1'b1) gen_d = GEN_IDLE;
                end else begin
                    tx_beat_d = tx_beat_q + 1'b1;
                end
            end
            if (rx_tvalid_i && !chk_run) begin
                err_beats_d = sat_inc(err_beats_q);
            end else if (rx_tvalid_i) begin
                if (data_err) err_beats_d = sat_inc(err_beats_q);
                if (early || missing) len_err_d = sat_inc(len_err_q);
                if ((data_err || early || missing) && !first_valid_q) begin
                    first_valid_d = 1'b1;
                    first_frame_d = rx_frames_q;
                    first_beat_d  = rx_beat_q;
                end
                if (missing) resync_d = 1'b1;
                if (rx_tlast_i) begin
                    rx_beat_d   = '0;
                    resync_d    = 1'b0;
                    rx_frames_d = sat_inc(rx_frames_q);
                    if (rx_frames_q == num_q - 1'b1) chk_d = CHK_IDLE;
                end else begin
                    rx_beat_d = rx_beat_q + 1'b1;
                end
            end
            if (busy && gen_d == GEN_IDLE && chk_d == CHK_IDLE) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gen_q <= GEN_IDLE;  chk_q <= CHK_IDLE;
            last_beat_q <= '0;  keep_last_q <= '0;  num_q <= '0;
            tx_beat_q <= '0;  rx_beat_q <= '0;
            tx_frames_q <= '0;  rx_frames_q <= '0;  err_beats_q <= '0;  len_err_q <= '0;
            first_valid_q <= 1'b0;  first_frame_q <= '0;  first_beat_q <= '0;
            done_q <= 1'b0;  resync_q <= 1'b0;
        end else begin
            gen_q <= gen_d;  chk_q <= chk_d;
            last_beat_q <= last_beat_d;  keep_last_q <= keep_last_d;  num_q <= num_d;
            tx_beat_q <= tx_beat_d;  rx_beat_q <= rx_beat_d;
            tx_frames_q <= tx_frames_d;  rx_frames_q <= rx_frames_d;
            err_beats_q <= err_beats_d;  len_err_q <= len_err_d;
            first_valid_q <= first_valid_d;  first_frame_q <= first_frame_d;  first_beat_q <= first_beat_d;
            done_q <= done_d;  resync_q <= resync_d;
        end
    end

    assign busy_o            = busy;
    assign done_o            = done_q;
    assign tx_frames_o       = tx_frames_q;
    assign rx_frames_o       = rx_frames_q;
    assign err_beats_o       = err_beats_q;
    assign len_err_o         = len_err_q;
    assign first_err_valid_o = first_valid_q;
    assign first_err_frame_o = first_frame_q;
    assign first_err_beat_o  = first_beat_q;

endmodule

// File: tb/tb_eth_frame_bist.sv
// tb/tb_eth_frame_bist.sv - directed loopback bench for eth_frame_bist
module tb_eth_frame_bist;
    localparam int DW = 64;
    localparam int LW = 16;
    localparam int CW = 32;
    localparam int B  = DW / 8;

    logic          clk = 1'b0;
    logic          rst, start, tx_tready;
    logic [LW-1:0] cfg_len;
    logic [CW-1:0] cfg_num;
    logic [1:0]    cfg_mode;
    logic [31:0]   cfg_seed;
    logic [DW-1:0] tx_tdata, rx_tdata;
    logic [B-1:0]  tx_tkeep, rx_tkeep;
    logic          tx_tlast, tx_tvalid, rx_tlast, rx_tvalid, rx_tready;
    logic          busy, done, fe_valid;
    logic [CW-1:0] tx_frames, rx_frames, err_beats, len_err, fe_frame;
    logic [LW-1:0] fe_beat;

    int   tb_f, tb_b;
    logic inj_en, et_en, stray;
    int   inj_f0, inj_b0, inj_f1, inj_b1, et_f, et_b;
    logic hit_flip, hit_tlast, hit_drop;

    int            n_checks = 0;
    int            n_fail = 0;
    int            tx_beats, nonff;
    logic [DW-1:0] last_data, beat1_data;
    logic [B-1:0]  last_keep;

    always #5 clk = ~clk;

    // Loopback path with optional bit flip, early tlast and dropped beats
    assign hit_flip  = inj_en && ((tb_f == inj_f0 && tb_b == inj_b0) || (tb_f == inj_f1 && tb_b == inj_b1));
    assign hit_tlast = et_en && tb_f == et_f && tb_b == et_b;
    assign hit_drop  = et_en && tb_f == et_f && tb_b > et_b;
    assign rx_tdata  = tx_tdata ^ {{(DW-1){1'b0}}, hit_flip};
    assign rx_tkeep  = tx_tkeep;
    assign rx_tlast  = tx_tlast | hit_tlast;
    assign rx_tvalid = (tx_tvalid && tx_tready && !hit_drop) || stray;

    always @(posedge clk) begin
        if (rst || start) begin
            tb_f <= 0;
            tb_b <= 0;
        end else if (tx_tvalid && tx_tready) begin
            if (tx_tlast) begin
                tb_f <= tb_f + 1;
                tb_b <= 0;
            end else begin
                tb_b <= tb_b + 1;
            end
        end
    end

    eth_frame_bist #(.DataWidth(DW), .LenWidth(LW), .CntWidth(CW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .cfg_len_i         (cfg_len),
        .cfg_num_frames_i  (cfg_num),
        .cfg_mode_i        (cfg_mode),
        .cfg_seed_i        (cfg_seed),
        .tx_tdata_o        (tx_tdata),
        .tx_tkeep_o        (tx_tkeep),
        .tx_tlast_o        (tx_tlast),
        .tx_tvalid_o       (tx_tvalid),
        .tx_tready_i       (tx_tready),
        .rx_tdata_i        (rx_tdata),
        .rx_tkeep_i        (rx_tkeep),
        .rx_tlast_i        (rx_tlast),
        .rx_tvalid_i       (rx_tvalid),
        .rx_tready_o       (rx_tready),
        .busy_o            (busy),
        .done_o            (done),
        .tx_frames_o       (tx_frames),
        .rx_frames_o       (rx_frames),
        .err_beats_o       (err_beats),
        .len_err_o         (len_err),
        .first_err_valid_o (fe_valid),
        .first_err_frame_o (fe_frame),
        .first_err_beat_o  (fe_beat)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [LW-1:0] len, input logic [CW-1:0] nf,
                            input logic [1:0] mode, input logic [31:0] seed);
        cfg_len  = len;
        cfg_num  = nf;
        cfg_mode = mode;
        cfg_seed = seed;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic run(input bit rnd, input int budget);
        logic [DW-1:0] pd;
        logic [B-1:0]  pk;
        logic          pl;
        bit            stalled;
        stalled  = 1'b0;
        tx_beats = 0;
        nonff    = 0;
        pd = '0;  pk = '0;  pl = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            if (stalled) begin
                check("stall_valid", 64'(tx_tvalid), 64'd1);
                check("stall_data", tx_tdata, pd);
                check("stall_keep", 64'(tx_tkeep), 64'(pk));
                check("stall_last", 64'(tx_tlast), 64'(pl));
            end
            tx_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled   = tx_tvalid && !tx_tready;
            pd = tx_tdata;  pk = tx_tkeep;  pl = tx_tlast;
            if (tx_tvalid && tx_tready) begin
                if (tx_tkeep !== 8'hFF) nonff++;
                if (tx_beats == 1) beat1_data = tx_tdata;
                if (tx_tlast) begin
                    last_data = tx_tdata;
                    last_keep = tx_tkeep;
                end
                tx_beats++;
            end
            @(negedge clk);
        end
        tx_tready = 1'b1;
        check("run_done", 64'(done), 64'd1);
        check("run_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;  start = 1'b0;  tx_tready = 1'b1;
        cfg_len = '0;  cfg_num = '0;  cfg_mode = 2'd0;  cfg_seed = '0;
        inj_en = 1'b0;  et_en = 1'b0;  stray = 1'b0;
        inj_f0 = 0;  inj_b0 = 0;  inj_f1 = 0;  inj_b1 = 0;  et_f = 0;  et_b = 0;
        last_data = '0;  beat1_data = '0;  last_keep = '0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(tx_tvalid), 64'd0);
        check("rst_tlast", 64'(tx_tlast), 64'd0);
        check("rst_tdata", tx_tdata, 64'd0);
        check("rst_tkeep", 64'(tx_tkeep), 64'd0);
        check("rst_rx_tready", 64'(rx_tready), 64'd1);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        check("rst_counters", 64'(tx_frames | rx_frames | err_beats | len_err), 64'd0);
        check("rst_first_err", {fe_valid, 15'd0, fe_beat, fe_frame}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // INCR, 64 bytes x 4 frames, full rate
        do_start(16'd64, 32'd4, 2'd0, 32'h0);
        check("incr_busy", 64'(busy), 64'd1);
        check("incr_tvalid", 64'(tx_tvalid), 64'd1);
        check("incr_beat0", tx_tdata, 64'h0706050403020100);
        run(1'b0, 200);
        check("incr_beats", 64'(tx_beats), 64'd32);
        check("incr_tx_frames", 64'(tx_frames), 64'd4);
        check("incr_rx_frames", 64'(rx_frames), 64'd4);
        check("incr_err_beats", 64'(err_beats), 64'd0);
        check("incr_len_err", 64'(len_err), 64'd0);
        check("incr_keep_ff", 64'(nonff), 64'd0);
        check("incr_last_data", last_data, 64'h4241403F3E3D3C3B);
        check("incr_no_first_err", 64'(fe_valid), 64'd0);

        // PRBS, 61 bytes x 2 frames
        do_start(16'd61, 32'd2, 2'd1, 32'h0000ACE1);
        check("prbs_done_clr", 64'(done), 64'd0);
        check("prbs_beat0", tx_tdata, 64'h0000ACE1_0000ACE1);
        run(1'b0, 200);
        check("prbs_beats", 64'(tx_beats), 64'd16);
        check("prbs_beat1", beat1_data, 64'h80205673_80205673);
        check("prbs_last_keep", 64'(last_keep), 64'h1F);
        check("prbs_rx_frames", 64'(rx_frames), 64'd2);
        check("prbs_err", 64'(err_beats | len_err), 64'd0);

        // PRBS seed 0 behaves as seed 1
        do_start(16'd8, 32'd2, 2'd1, 32'h0);
        check("seed0_beat0", tx_tdata, 64'h00000001_00000001);
        run(1'b0, 100);
        check("seed0_beat1", beat1_data, 64'h80200003_80200003);
        check("seed0_beats", 64'(tx_beats), 64'd2);
        check("seed0_err", 64'(err_beats | len_err), 64'd0);

        // INCR with random back-pressure
        do_start(16'd64, 32'd4, 2'd0, 32'h0);
        run(1'b1, 600);
        check("rnd_beats", 64'(tx_beats), 64'd32);
        check("rnd_tx_frames", 64'(tx_frames), 64'd4);
        check("rnd_rx_frames", 64'(rx_frames), 64'd4);
        check("rnd_err", 64'(err_beats | len_err), 64'd0);
        check("rnd_last_data", last_data, 64'h4241403F3E3D3C3B);

        // Bit flips at frame 2 beat 3, then frame 3 beat 1
        inj_en = 1'b1;  inj_f0 = 2;  inj_b0 = 3;  inj_f1 = 3;  inj_b1 = 1;
        do_start(16'd64, 32'd4, 2'd0, 32'h0);
        run(1'b0, 200);
        inj_en = 1'b0;
        check("inj_err_beats", 64'(err_beats), 64'd2);
        check("inj_len_err", 64'(len_err), 64'd0);
        check("inj_fe_valid", 64'(fe_valid), 64'd1);
        check("inj_fe_frame", 64'(fe_frame), 64'd2);
        check("inj_fe_beat", 64'(fe_beat), 64'd3);
        check("inj_rx_frames", 64'(rx_frames), 64'd4);

        // Early tlast on beat 5 of frame 0, remainder of that frame dropped
        et_en = 1'b1;  et_f = 0;  et_b = 5;
        do_start(16'd64, 32'd3, 2'd0, 32'h0);
        run(1'b0, 200);
        et_en = 1'b0;
        check("early_len_err", 64'(len_err), 64'd1);
        check("early_err_beats", 64'(err_beats), 64'd0);
        check("early_rx_frames", 64'(rx_frames), 64'd3);
        check("early_tx_frames", 64'(tx_frames), 64'd3);
        check("early_fe", {fe_valid, 15'd0, fe_beat, fe_frame}, {1'b1, 15'd0, 16'd5, 32'd0});
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("stray_err_beats", 64'(err_beats), 64'd1);

        // Reserved mode 3 acts as CONST with seed[7:0]
        do_start(16'd4, 32'd1, 2'd3, 32'h1234_565A);
        check("const_keep", 64'(tx_tkeep), 64'h0F);
        check("const_tlast", 64'(tx_tlast), 64'd1);
        check("const_data", tx_tdata & 64'h0000_0000_FFFF_FFFF, 64'h5A5A5A5A);
        run(1'b0, 50);
        check("const_result", {32'(rx_frames), 32'(err_beats | len_err)}, {32'd1, 32'd0});

        // Starts with zero length or zero frame count are ignored
        do_start(16'd0, 32'd4, 2'd0, 32'h0);
        check("len0_busy", {62'd0, busy, tx_tvalid}, 64'd0);
        check("len0_done_kept", 64'(done), 64'd1);
        do_start(16'd64, 32'd0, 2'd0, 32'h0);
        check("nf0_busy", 64'(busy), 64'd0);

        // Reset mid-run, then a clean rerun
        do_start(16'd64, 32'd4, 2'd0, 32'h0);
        repeat (10) @(negedge clk);
        check("mid_tx_frames", 64'(tx_frames), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_tx", {tx_tdata[31:0], 22'd0, tx_tkeep, tx_tlast, tx_tvalid}, 64'd0);
        check("mrst_status", {62'd0, busy, done}, 64'd0);
        check("mrst_counters", 64'(tx_frames | rx_frames | err_beats | len_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        do_start(16'd64, 32'd4, 2'd0, 32'h0);
        run(1'b0, 200);
        check("rerun_frames", {32'(tx_frames), 32'(rx_frames)}, {32'd4, 32'd4});
        check("rerun_err", 64'(err_beats | len_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
